// File: rtl/arm_regfile.sv
// arm_regfile: ARM register file, R0-R14 in flops, R15 reads return the external PC+8
//   clk, reset_n   : rising-edge clock, asynchronous active-low reset clearing R0-R14
//   RegWrite/WA3/WD3 : write port, commits on the rising edge; WA3 == 15 is ignored
//   RA1/RD1, RA2/RD2 : independent combinational read ports, address 15 returns R15
//   REGFILE_BYPASS_EN : when defined, a same-cycle write to RAx is forwarded to RDx
module arm_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] RA1,
    input  logic [ADDR_WIDTH-1:0] RA2,
    input  logic [ADDR_WIDTH-1:0] WA3,
    input  logic [DATA_WIDTH-1:0] WD3,
    input  logic [DATA_WIDTH-1:0] R15,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2
);
    localparam int N = 2**ADDR_WIDTH - 1;
    localparam logic [ADDR_WIDTH-1:0] PC_ADDR = '1;
    logic [DATA_WIDTH-1:0] regs [N];
    logic wr;
    assign wr = RegWrite && (WA3 != PC_ADDR);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
        end else if (wr) begin
            regs[WA3] <= WD3;
        end
    end
    always_comb begin
        RD1 = (RA1 == PC_ADDR) ? R15 : regs[RA1];
        RD2 = (RA2 == PC_ADDR) ? R15 : regs[RA2];
`ifdef REGFILE_BYPASS_EN
        // forwarding is held off during reset so reads show the cleared state
        if (reset_n && wr && RA1 == WA3) RD1 = WD3;
        if (reset_n && wr && RA2 == WA3) RD2 = WD3;
`endif
    end
endmodule

// File: tb/tb_arm_regfile.sv
// tb_arm_regfile: randomized and directed checks of arm_regfile against an array model
module tb_arm_regfile;
    logic        clk = 0;
    logic        reset_n, we;
    logic [3:0]  ra1, ra2, wa;
    logic [31:0] wd, r15, rd1, rd2, alu_result;
    logic [31:0] model [15];
    int total = 0, bad = 0;

    arm_regfile dut (
        .clk(clk), .reset_n(reset_n), .RegWrite(we),
        .RA1(ra1), .RA2(ra2), .WA3(wa), .WD3(wd), .R15(r15),
        .RD1(rd1), .RD2(rd2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        if (a == 4'd15) return r15;
`ifdef REGFILE_BYPASS_EN
        if (reset_n && we && wa != 4'd15 && a == wa) return wd;
`endif
        return model[a];
    endfunction

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ctl);
        case (ctl)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b10: return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_reads();
        chk("rd1", rd1, exp_rd(ra1));
        chk("rd2", rd2, exp_rd(ra2));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset_n && we && wa != 4'd15) model[wa] = wd;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 15; i++) model[i] = '0;
    endtask

    initial begin
        reset_n = 0; we = 0; wa = 0; wd = 0; ra1 = 0; ra2 = 0; r15 = 32'h8;
        clear_model();
        #12 reset_n = 1;
        repeat (30) begin
            we = 1; wa = 4'($urandom_range(0, 14)); wd = $urandom;
            ra1 = 4'($urandom_range(0, 15)); ra2 = 4'($urandom_range(0, 15));
            #1 check_reads();
            cycle();
            check_reads();
        end
        // asynchronous reset over arbitrary contents, write enable still high
        reset_n = 0;
        clear_model();
        for (int a = 0; a < 15; a++) begin
            ra1 = 4'(a); ra2 = 4'(14 - a);
            #1 chk("reset_rd1", rd1, 32'h0);
            chk("reset_rd2", rd2, 32'h0);
        end
        ra1 = 4'd15; r15 = 32'h108;
        #1 chk("reset_r15", rd1, 32'h108);
        @(negedge clk);
        reset_n = 1; we = 0; r15 = 32'h8;
        // basic write/read
        we = 1; wa = 4'd3; wd = 32'hDEAD_BEEF;
        cycle();
        we = 0; ra1 = 4'd3; ra2 = 4'd3;
        #1 chk("basic_rd1", rd1, 32'hDEAD_BEEF);
        chk("basic_rd2", rd2, 32'hDEAD_BEEF);
        ra1 = 4'd4;
        #1 chk("basic_other", rd1, 32'h0);
        // write disabled, and write to R15 ignored
        we = 0; wa = 4'd4; wd = 32'h1;
        cycle();
        ra1 = 4'd4;
        #1 chk("we0_r4", rd1, 32'h0);
        we = 1; wa = 4'd15; wd = 32'h5555_5555;
        cycle();
        we = 0; ra1 = 4'd15;
        #1 chk("r15_write_ignored", rd1, 32'h8);
        for (int a = 0; a < 15; a++) begin
            ra2 = 4'(a);
            #1 chk("unchanged", rd2, model[a]);
        end
        // read during write
        we = 1; wa = 4'd5; wd = 32'h1;
        cycle();
        wd = 32'h2; ra1 = 4'd5;
`ifdef REGFILE_BYPASS_EN
        #1 chk("rdw_before", rd1, 32'h2);
`else
        #1 chk("rdw_before", rd1, 32'h1);
`endif
        cycle();
        chk("rdw_after", rd1, 32'h2);
        // reset in the middle of a write
        we = 1; wa = 4'd7; wd = 32'hFF;
        cycle();
        chk("r7_ff", rd1 == rd1 ? model[7] : 32'h0, 32'hFF);
        wd = 32'hAAAA_AAAA; ra1 = 4'd7;
        #1 reset_n = 0;
        clear_model();
        #1 chk("midreset_drop", rd1, 32'h0);
        repeat (2) @(posedge clk);
        #1 chk("midreset_nowrite", rd1, 32'h0);
        @(negedge clk);
        reset_n = 1;
        cycle();
        chk("midreset_release", rd1, 32'hAAAA_AAAA);
        // ALU handoff: R1 - R2 written back to R0
        we = 1; wa = 4'd0; wd = 32'h1234;
        cycle();
        wa = 4'd1; wd = 32'h1;
        cycle();
        wa = 4'd2;
        cycle();
        we = 0; ra1 = 4'd1; ra2 = 4'd2;
        #1 alu_result = alu(rd1, rd2, 2'b01);
        chk("alu_result", alu_result, 32'h0);
        we = 1; wa = 4'd0; wd = alu_result;
        cycle();
        we = 0; ra1 = 4'd0;
        #1 chk("alu_writeback", rd1, 32'h0);
        // random mix with enables and the R15 address
        repeat (200) begin
            we = 1'($urandom_range(0, 1)); wa = 4'($urandom_range(0, 15)); wd = $urandom;
            ra1 = 4'($urandom_range(0, 15)); ra2 = 4'($urandom_range(0, 15)); r15 = $urandom;
            #1 check_reads();
            cycle();
            check_reads();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
